// File: rtl/mac_array_dual.sv
// mac_array_dual: row x col systolic MAC array with weight-stationary (WS) and output-stationary (OS) dataflow.
// Instructions skew diagonally; OS accumulators drain south through an output holding register.
module mac_array_dual #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 4,
  parameter int row     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [row*bw-1:0]      in_w,
  input  logic [col*psum_bw-1:0] in_n,
  input  logic [1:0]             inst_w,
  input  logic                   mode,
  output logic [col*psum_bw-1:0] out_s,
  output logic [col-1:0]         valid
);
  logic [1:0]             r_sk  [row-1];
  logic [bw-1:0]          r_a   [row][col];
  logic [bw-1:0]          r_b   [row][col];
  logic [bw-1:0]          r_w   [row][col];
  logic [1:0]             r_i   [row][col];
  logic [psum_bw-1:0]     r_c   [row][col];
  logic [psum_bw-1:0]     r_drn [col];
  logic [col-1:0]         r_vld;
  logic [1:0]             w_ri  [row];
  logic [1:0]             w_ii  [row][col];
  logic [bw-1:0]          w_ai  [row][col];
  logic [bw-1:0]          w_bi  [row][col];
  logic [bw-1:0]          w_wi  [row][col];
  logic [bw-1:0]          w_m   [row][col];
  logic [psum_bw-1:0]     w_ci  [row][col];
  logic [psum_bw-1:0]     w_pe  [row][col];
  logic [psum_bw-1:0]     w_sum [row][col];
  logic signed [2*bw-1:0] w_p   [row][col];
  logic [row-1:0]         w_ld;
  logic [col-1:0]         w_exr;
  logic                   w_dr;
  assign w_dr = mode && inst_w == 2'b11;
  genvar r, c;
  for (r = 0; r < row; r++) begin : g_r
    if (r == 0) begin : g_top
      assign w_ri[r] = inst_w;
    end else begin : g_dly
      assign w_ri[r] = r_sk[r-1];
    end
    // weight load shifts the whole row at once, so the first value ends up furthest east
    assign w_ld[r] = !mode && w_ri[r] == 2'b01;
    for (c = 0; c < col; c++) begin : g_c
      if (c == 0) begin : g_west
        assign w_ii[r][c] = w_ri[r];
        assign w_ai[r][c] = in_w[r*bw +: bw];
        assign w_bi[r][c] = in_w[r*bw +: bw];
      end else begin : g_east
        assign w_ii[r][c] = r_i[r][c-1];
        assign w_ai[r][c] = r_a[r][c-1];
        assign w_bi[r][c] = r_b[r][c-1];
      end
      if (r == 0) begin : g_north
        assign w_ci[r][c] = in_n[c*psum_bw +: psum_bw];
        assign w_wi[r][c] = in_n[c*psum_bw +: bw];
      end else begin : g_south
        assign w_ci[r][c] = r_c[r-1][c];
        assign w_wi[r][c] = r_w[r-1][c];
      end
      assign w_m[r][c]   = mode ? w_wi[r][c] : r_b[r][c];
      assign w_p[r][c]   = $signed({{bw{1'b0}}, w_ai[r][c]}) * $signed({{bw{w_m[r][c][bw-1]}}, w_m[r][c]});
      assign w_pe[r][c]  = {{(psum_bw-2*bw){w_p[r][c][2*bw-1]}}, w_p[r][c]};
      assign w_sum[r][c] = (mode ? r_c[r][c] : w_ci[r][c]) + w_pe[r][c];
    end
  end
  for (c = 0; c < col; c++) begin : g_o
    assign w_exr[c] = w_ii[row-1][c] == 2'b10;
    assign out_s[c*psum_bw +: psum_bw] = mode ? r_drn[c] : r_c[row-1][c];
  end
  assign valid = r_vld;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < row; i++)
        for (int j = 0; j < col; j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= '0;
          r_w[i][j] <= '0;
          r_i[i][j] <= '0;
          r_c[i][j] <= '0;
        end
      for (int k = 0; k < row-1; k++) r_sk[k] <= '0;
      for (int j = 0; j < col; j++) r_drn[j] <= '0;
      r_vld <= '0;
    end else begin
      for (int i = 0; i < row; i++)
        for (int j = 0; j < col; j++) begin
          r_i[i][j] <= w_ii[i][j];
          if (w_ld[i]) r_b[i][j] <= w_bi[i][j];
          if (w_ii[i][j] == 2'b10) begin
            r_a[i][j] <= w_ai[i][j];
            r_c[i][j] <= w_sum[i][j];
            if (mode) r_w[i][j] <= w_wi[i][j];
          end
          if (w_dr) r_c[i][j] <= i == 0 ? '0 : r_c[i-1][j];
        end
      r_sk[0] <= inst_w;
      for (int k = 1; k < row-1; k++) r_sk[k] <= r_sk[k-1];
      for (int j = 0; j < col; j++) if (w_dr) r_drn[j] <= r_c[row-1][j];
      r_vld <= mode ? {col{w_dr}} : w_exr;
    end
endmodule
